// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: checks and issues one memory op per cycle, formats load data,
// and holds the result in the MEM/WB register with exception flags and event counters.
module mem_stage_lsu #(
    parameter int MEM_BYTES = 1024,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mem_read,
    input  logic             in_mem_write,
    input  logic [2:0]       in_funct3,
    input  logic [31:0]      in_addr,
    input  logic [31:0]      in_store_data,
    input  logic [31:0]      in_alu_result,
    input  logic [4:0]       in_rd,
    input  logic             in_reg_write,
    output logic [31:0]      dm_addr,
    output logic [31:0]      dm_write_data,
    output logic             dm_read_en,
    output logic             dm_write_byte_en,
    output logic             dm_write_half_en,
    output logic             dm_write_word_en,
    input  logic [31:0]      dm_read_data,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [4:0]       wb_rd,
    output logic             wb_reg_write,
    output logic [31:0]      wb_data,
    output logic             wb_exc,
    output logic [1:0]       wb_exc_cause,
    output logic             err_sticky,
    input  logic             err_clr,
    output logic [CNT_W-1:0] load_cnt,
    output logic [CNT_W-1:0] store_cnt
);

    logic             fire;
    logic             is_mem;
    logic             illegal;
    logic             misaligned;
    logic             out_of_range;
    logic             exc;
    logic             issue_ok;
    logic [1:0]       cause;
    logic [2:0]       size_bytes;
    logic [32:0]      last_byte;

    logic             wb_valid_q, wb_valid_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic             wb_reg_write_q, wb_reg_write_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic             wb_exc_q, wb_exc_d;
    logic [1:0]       wb_exc_cause_q, wb_exc_cause_d;
    logic             err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
    logic [CNT_W-1:0] store_cnt_q, store_cnt_d;

    // dm_read_data is already aligned to the access address, so only extension is needed.
    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [31:0] raw);
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        sb = signed'(raw[7:0]);
        sh = signed'(raw[15:0]);
        case (f3)
            3'b000:  fmt_load = 32'(sb);
            3'b001:  fmt_load = 32'(sh);
            3'b100:  fmt_load = {24'd0, raw[7:0]};
            3'b101:  fmt_load = {16'd0, raw[15:0]};
            default: fmt_load = raw;
        endcase
    endfunction

    assign in_ready      = !wb_valid_q | wb_ready;
    assign fire          = in_valid & in_ready;
    assign dm_addr       = in_addr;
    assign dm_write_data = in_store_data;
    assign is_mem        = in_mem_read | in_mem_write;

    always_comb begin
        case (in_funct3[1:0])
            2'b00:   size_bytes = 3'd1;
            2'b01:   size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
        // 33-bit end address so an access near 0xFFFFFFFF cannot wrap into range.
        last_byte    = {1'b0, in_addr} + 33'(size_bytes) - 33'd1;
        out_of_range = last_byte >= 33'(MEM_BYTES);
        misaligned   = ((in_funct3[1:0] == 2'b01) & in_addr[0]) |
                       ((in_funct3[1:0] == 2'b10) & (in_addr[1:0] != 2'b00));
        illegal      = (in_mem_read & in_mem_write) |
                       (in_mem_read & !(in_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) |
                       (in_mem_write & !(in_funct3 inside {3'b000, 3'b001, 3'b010}));
        cause = 2'b00;
        if (is_mem) begin
            if (illegal)           cause = 2'b11;
            else if (misaligned)   cause = 2'b01;
            else if (out_of_range) cause = 2'b10;
        end
        exc = (cause != 2'b00);
    end

    assign issue_ok         = fire & !rst & !exc;
    assign dm_read_en       = issue_ok & in_mem_read;
    assign dm_write_byte_en = issue_ok & in_mem_write & (in_funct3[1:0] == 2'b00);
    assign dm_write_half_en = issue_ok & in_mem_write & (in_funct3[1:0] == 2'b01);
    assign dm_write_word_en = issue_ok & in_mem_write & (in_funct3[1:0] == 2'b10);

    always_comb begin
        wb_valid_d     = wb_valid_q;
        wb_rd_d        = wb_rd_q;
        wb_reg_write_d = wb_reg_write_q;
        wb_data_d      = wb_data_q;
        wb_exc_d       = wb_exc_q;
        wb_exc_cause_d = wb_exc_cause_q;
        if (fire) begin
            wb_valid_d     = 1'b1;
            wb_rd_d        = in_rd;
            wb_reg_write_d = in_reg_write & !exc & !in_mem_write;
            wb_exc_d       = exc;
            wb_exc_cause_d = cause;
            if (exc || in_mem_write) wb_data_d = 32'd0;
            else if (in_mem_read)    wb_data_d = fmt_load(in_funct3, dm_read_data);
            else                     wb_data_d = in_alu_result;
        end else if (wb_ready) begin
            wb_valid_d = 1'b0;
        end

        err_sticky_d = err_sticky_q;
        if (fire && exc) err_sticky_d = 1'b1;
        else if (err_clr) err_sticky_d = 1'b0;

        load_cnt_d  = load_cnt_q + (dm_read_en ? CNT_W'(1) : CNT_W'(0));
        store_cnt_d = store_cnt_q +
                      ((dm_write_byte_en | dm_write_half_en | dm_write_word_en) ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= 5'd0;
            wb_reg_write_q <= 1'b0;
            wb_data_q      <= 32'd0;
            wb_exc_q       <= 1'b0;
            wb_exc_cause_q <= 2'b00;
            err_sticky_q   <= 1'b0;
            load_cnt_q     <= '0;
            store_cnt_q    <= '0;
        end else begin
            wb_valid_q     <= wb_valid_d;
            wb_rd_q        <= wb_rd_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_data_q      <= wb_data_d;
            wb_exc_q       <= wb_exc_d;
            wb_exc_cause_q <= wb_exc_cause_d;
            err_sticky_q   <= err_sticky_d;
            load_cnt_q     <= load_cnt_d;
            store_cnt_q    <= store_cnt_d;
        end
    end

    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_data      = wb_data_q;
    assign wb_exc       = wb_exc_q;
    assign wb_exc_cause = wb_exc_cause_q;
    assign err_sticky   = err_sticky_q;
    assign load_cnt     = load_cnt_q;
    assign store_cnt    = store_cnt_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: byte-addressed memory model, directed vector table,
// and hand-written backpressure, sticky-error and reset sequences.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_mem_read, in_mem_write;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_store_data, in_alu_result;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic [31:0] dm_addr, dm_write_data, dm_read_data;
    logic        dm_read_en, dm_write_byte_en, dm_write_half_en, dm_write_word_en;
    logic        wb_valid, wb_ready, wb_reg_write, wb_exc, err_sticky, err_clr;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  wb_exc_cause;
    logic [15:0] load_cnt, store_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.MEM_BYTES(1024), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_funct3(in_funct3), .in_addr(in_addr),
        .in_store_data(in_store_data), .in_alu_result(in_alu_result),
        .in_rd(in_rd), .in_reg_write(in_reg_write),
        .dm_addr(dm_addr), .dm_write_data(dm_write_data),
        .dm_read_en(dm_read_en), .dm_write_byte_en(dm_write_byte_en),
        .dm_write_half_en(dm_write_half_en), .dm_write_word_en(dm_write_word_en),
        .dm_read_data(dm_read_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .wb_exc(wb_exc), .wb_exc_cause(wb_exc_cause),
        .err_sticky(err_sticky), .err_clr(err_clr),
        .load_cnt(load_cnt), .store_cnt(store_cnt)
    );

    // Data memory model: combinational read, write at posedge.
    logic [7:0]  mem [0:1023];
    logic [32:0] a0, a1, a2, a3;
    assign a0 = {1'b0, dm_addr};
    assign a1 = a0 + 33'd1;
    assign a2 = a0 + 33'd2;
    assign a3 = a0 + 33'd3;
    assign dm_read_data = {(a3 < 33'd1024) ? mem[a3[9:0]] : 8'h00,
                           (a2 < 33'd1024) ? mem[a2[9:0]] : 8'h00,
                           (a1 < 33'd1024) ? mem[a1[9:0]] : 8'h00,
                           (a0 < 33'd1024) ? mem[a0[9:0]] : 8'h00};

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end

    always @(posedge clk) begin
        if (dm_write_byte_en && a0 < 33'd1024) mem[a0[9:0]] <= dm_write_data[7:0];
        if (dm_write_half_en && a1 < 33'd1024) begin
            mem[a0[9:0]] <= dm_write_data[7:0];
            mem[a1[9:0]] <= dm_write_data[15:8];
        end
        if (dm_write_word_en && a3 < 33'd1024) begin
            mem[a0[9:0]] <= dm_write_data[7:0];
            mem[a1[9:0]] <= dm_write_data[15:8];
            mem[a2[9:0]] <= dm_write_data[23:16];
            mem[a3[9:0]] <= dm_write_data[31:24];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rd_op, input logic wr_op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata);
        in_valid      = v;
        in_mem_read   = rd_op;
        in_mem_write  = wr_op;
        in_funct3     = f3;
        in_addr       = addr;
        in_store_data = sdata;
    endtask

    typedef struct {
        logic        rd_op;
        logic        wr_op;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] alu;
        logic [3:0]  en;      // {read, byte, half, word}
        logic [31:0] exp_data;
        logic        exp_exc;
        logic [1:0]  cause;
        logic        exp_regw;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic w, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [31:0] alu, input logic [3:0] en,
                       input logic [31:0] d, input logic e, input logic [1:0] c, input logic rw);
        vec_t v;
        v.rd_op = r; v.wr_op = w; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.alu = alu;
        v.en = en; v.exp_data = d; v.exp_exc = e; v.cause = c; v.exp_regw = rw;
        vq.push_back(v);
    endtask

    initial begin
        int exp_loads;
        int exp_stores;
        exp_loads  = 0;
        exp_stores = 0;

        //   r  w  f3      addr          sdata         alu           en       data          e  c      rw
        add(0, 1, 3'b010, 32'h10,       32'hDEADBEEF, 32'h0,        4'b0001, 32'h0,        0, 2'b00, 0);
        add(1, 0, 3'b010, 32'h10,       32'h0,        32'h0,        4'b1000, 32'hDEADBEEF, 0, 2'b00, 1);
        add(0, 1, 3'b000, 32'h20,       32'h00000080, 32'h0,        4'b0100, 32'h0,        0, 2'b00, 0);
        add(1, 0, 3'b000, 32'h20,       32'h0,        32'h0,        4'b1000, 32'hFFFFFF80, 0, 2'b00, 1);
        add(1, 0, 3'b100, 32'h20,       32'h0,        32'h0,        4'b1000, 32'h00000080, 0, 2'b00, 1);
        add(0, 1, 3'b001, 32'h22,       32'h00008001, 32'h0,        4'b0010, 32'h0,        0, 2'b00, 0);
        add(1, 0, 3'b001, 32'h22,       32'h0,        32'h0,        4'b1000, 32'hFFFF8001, 0, 2'b00, 1);
        add(1, 0, 3'b101, 32'h22,       32'h0,        32'h0,        4'b1000, 32'h00008001, 0, 2'b00, 1);
        add(1, 0, 3'b010, 32'h13,       32'h0,        32'h0,        4'b0000, 32'h0,        1, 2'b01, 0);
        add(0, 1, 3'b001, 32'h15,       32'h00001234, 32'h0,        4'b0000, 32'h0,        1, 2'b01, 0);
        add(0, 1, 3'b010, 32'h3FC,      32'h11223344, 32'h0,        4'b0001, 32'h0,        0, 2'b00, 0);
        add(1, 0, 3'b010, 32'h3FC,      32'h0,        32'h0,        4'b1000, 32'h11223344, 0, 2'b00, 1);
        add(1, 0, 3'b010, 32'h3FD,      32'h0,        32'h0,        4'b0000, 32'h0,        1, 2'b01, 0);
        add(1, 0, 3'b000, 32'h400,      32'h0,        32'h0,        4'b0000, 32'h0,        1, 2'b10, 0);
        add(1, 0, 3'b010, 32'hFFFFFFFC, 32'h0,        32'h0,        4'b0000, 32'h0,        1, 2'b10, 0);
        add(0, 1, 3'b100, 32'h40,       32'h0,        32'h0,        4'b0000, 32'h0,        1, 2'b11, 0);
        add(1, 1, 3'b010, 32'h40,       32'h0,        32'h0,        4'b0000, 32'h0,        1, 2'b11, 0);
        add(1, 0, 3'b011, 32'h40,       32'h0,        32'h0,        4'b0000, 32'h0,        1, 2'b11, 0);
        add(0, 0, 3'b010, 32'h3,        32'h0,        32'hCAFEF00D, 4'b0000, 32'hCAFEF00D, 0, 2'b00, 1);
        add(1, 0, 3'b111, 32'h3,        32'h0,        32'h0,        4'b0000, 32'h0,        1, 2'b11, 0);
        add(1, 0, 3'b001, 32'h401,      32'h0,        32'h0,        4'b0000, 32'h0,        1, 2'b01, 0);
        add(1, 0, 3'b001, 32'h3FF,      32'h0,        32'h0,        4'b0000, 32'h0,        1, 2'b01, 0);
        add(1, 0, 3'b001, 32'h3FE,      32'h0,        32'h0,        4'b1000, 32'h00001122, 0, 2'b00, 1);

        // Reset: enables gated even with a store presented.
        rst = 1'b1; wb_ready = 1'b1; err_clr = 1'b0;
        in_alu_result = 32'h0; in_rd = 5'd0; in_reg_write = 1'b1;
        drive(1, 0, 1, 3'b010, 32'h30, 32'h55555555);
        #2;
        chk("reset_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("reset_wb_data", wb_data, 32'd0);
        chk("reset_wb_misc", {20'd0, wb_rd, wb_reg_write, wb_exc, wb_exc_cause, err_sticky}, 32'd0);
        chk("reset_cnts", {load_cnt, store_cnt}, 32'd0);
        chk("reset_enables", {28'd0, dm_read_en, dm_write_byte_en, dm_write_half_en, dm_write_word_en}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk("reset_no_write", {24'd0, mem[10'h30]}, 32'd0);

        foreach (vq[i]) begin
            drive(1, vq[i].rd_op, vq[i].wr_op, vq[i].f3, vq[i].addr, vq[i].sdata);
            in_alu_result = vq[i].alu;
            in_rd         = 5'(i + 1);
            #2;
            chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            chk($sformatf("v%0d_enables", i),
                {28'd0, dm_read_en, dm_write_byte_en, dm_write_half_en, dm_write_word_en}, {28'd0, vq[i].en});
            @(posedge clk); #1;
            chk($sformatf("v%0d_wb_data", i), wb_data, vq[i].exp_data);
            chk($sformatf("v%0d_wb_flags", i), {27'd0, wb_valid, wb_exc, wb_exc_cause, wb_reg_write},
                {27'd0, 1'b1, vq[i].exp_exc, vq[i].cause, vq[i].exp_regw});
            chk($sformatf("v%0d_wb_rd", i), {27'd0, wb_rd}, 32'(i + 1));
            if (!vq[i].exp_exc && vq[i].rd_op) exp_loads++;
            if (!vq[i].exp_exc && vq[i].wr_op) exp_stores++;
        end
        chk("table_load_cnt", {16'd0, load_cnt}, 32'(exp_loads));
        chk("table_store_cnt", {16'd0, store_cnt}, 32'(exp_stores));
        chk("misaligned_sh_mem", {16'd0, mem[10'h15], mem[10'h14]}, 32'd0);

        // Sticky error: holds, clears with err_clr, and set wins over clear.
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk("err_sticky_held", {31'd0, err_sticky}, 32'd1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        chk("err_sticky_cleared", {31'd0, err_sticky}, 32'd0);
        drive(1, 1, 0, 3'b010, 32'h13, 32'h0);
        @(posedge clk); #1;
        chk("err_sticky_set_wins", {31'd0, err_sticky}, 32'd1);
        err_clr = 1'b0;
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk("idle_drains_wb", {31'd0, wb_valid}, 32'd0);

        // Backpressure: load held in WB, byte store waits in EX.
        wb_ready = 1'b0;
        drive(1, 1, 0, 3'b010, 32'h10, 32'h0);
        @(posedge clk); #1;
        drive(1, 0, 1, 3'b000, 32'h10, 32'h00000077);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
            chk($sformatf("bp%0d_byte_en", c), {31'd0, dm_write_byte_en}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("bp%0d_wb_data", c), wb_data, 32'hDEADBEEF);
            chk($sformatf("bp%0d_mem", c), {24'd0, mem[10'h10]}, 32'h000000EF);
        end
        wb_ready = 1'b1;
        #1;
        chk("bp_release_byte_en", {31'd0, dm_write_byte_en}, 32'd1);
        @(posedge clk); #1;
        chk("bp_commit_mem", {24'd0, mem[10'h10]}, 32'h00000077);
        chk("bp_store_wb", {wb_data[30:0], wb_valid}, 32'd1);
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk("bp_drain", {31'd0, wb_valid}, 32'd0);
        chk("bp_cnts", {load_cnt, store_cnt}, {16'(exp_loads + 1), 16'(exp_stores + 1)});

        // Reset asserted mid-stall with a store waiting; the freed slot must not write.
        wb_ready = 1'b0;
        drive(1, 1, 0, 3'b010, 32'h10, 32'h0);
        @(posedge clk); #1;
        drive(1, 0, 1, 3'b010, 32'h30, 32'h55555555);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_mid_cnts", {load_cnt, store_cnt}, 32'd0);
        chk("rst_mid_word_en", {31'd0, dm_write_word_en}, 32'd0);
        @(posedge clk); #1;
        chk("rst_mid_mem", {mem[10'h33], mem[10'h32], mem[10'h31], mem[10'h30]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
